// File: rtl/wb_regfile.sv
// Writeback-stage register file: load extraction, commit, bypass, retire count.
// Ports: clk, rst_n, *_from_wb writeback bundle, rs1/rs2 read ports, load_misalign, retire_cnt.
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_from_wb,
  input  logic        write_reg_from_wb,
  input  logic        read_mem_from_wb,
  input  logic [2:0]  funct3_from_wb,
  input  logic [31:0] result_from_wb,
  input  logic [31:0] data_from_mem_from_wb,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        load_misalign,
  output logic [31:0] retire_cnt
);

  logic [31:0] regs [1:31];
  logic [31:0] cnt_q;
  logic        mis_q;

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        sx;
  logic        ld_b;
  logic        ld_h;
  logic        ld_w;
  logic        alu;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] wb_val;
  logic        mis_now;
  logic        commit;

  // Undefined size codes (011/110/111) fall through to word loads.
  always_comb begin
    is_b = (funct3_from_wb[1:0] == 2'b00);
    is_h = (funct3_from_wb[1:0] == 2'b01) &&
           !(funct3_from_wb == 3'b111);
    is_w = !(is_b || is_h);
    sx   = !funct3_from_wb[2];
  end

  always_comb begin
    ld_b = read_mem_from_wb && is_b;
    ld_h = read_mem_from_wb && is_h;
    ld_w = read_mem_from_wb && is_w;
    alu  = !read_mem_from_wb;
  end

  always_comb begin
    byte_v = data_from_mem_from_wb[7:0];
    unique case (result_from_wb[1:0])
      2'd0: byte_v = data_from_mem_from_wb[7:0];
      2'd1: byte_v = data_from_mem_from_wb[15:8];
      2'd2: byte_v = data_from_mem_from_wb[23:16];
      2'd3: byte_v = data_from_mem_from_wb[31:24];
      default: byte_v = data_from_mem_from_wb[7:0];
    endcase
  end

  always_comb begin
    half_v = result_from_wb[1] ?
             data_from_mem_from_wb[31:16] :
             data_from_mem_from_wb[15:0];
  end

  always_comb begin
    wb_val = result_from_wb;
    unique case (1'b1)
      alu:  wb_val = result_from_wb;
      ld_b: wb_val = {{24{sx & byte_v[7]}}, byte_v};
      ld_h: wb_val = {{16{sx & half_v[15]}}, half_v};
      ld_w: wb_val = data_from_mem_from_wb;
      default: wb_val = result_from_wb;
    endcase
  end

  // Gated on the write enable so idle (possibly X) inputs
  // never raise a misalign pulse.
  always_comb begin
    mis_now = write_reg_from_wb && read_mem_from_wb &&
              ((is_h && result_from_wb[0]) ||
               (is_w && (result_from_wb[1:0] != 2'b00)));
    commit  = write_reg_from_wb &&
              (rd_from_wb != 5'd0) && !mis_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (commit) begin
      regs[rd_from_wb] <= wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_now;
      if (commit) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Read ports: index 0 and reset force zero, then bypass, then storage.
  always_comb begin
    rs1_data = 32'd0;
    if (rst_n && (rs1_addr != 5'd0)) begin
      if (commit && (rs1_addr == rd_from_wb)) begin
        rs1_data = wb_val;
      end else begin
        rs1_data = regs[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = 32'd0;
    if (rst_n && (rs2_addr != 5'd0)) begin
      if (commit && (rs2_addr == rd_from_wb)) begin
        rs2_data = wb_val;
      end else begin
        rs2_data = regs[rs2_addr];
      end
    end
  end

  assign load_misalign = mis_q;
  assign retire_cnt    = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile with a behavioural register-file model.
// Directed literal cases pin the model; a negedge process compares every cycle.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_from_wb;
  logic        write_reg_from_wb;
  logic        read_mem_from_wb;
  logic [2:0]  funct3_from_wb;
  logic [31:0] result_from_wb;
  logic [31:0] data_from_mem_from_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        load_misalign;
  logic [31:0] retire_cnt;

  int checks;
  int failures;
  bit chk_en;

  logic [31:0] m_reg [32];
  logic [31:0] m_cnt;
  logic        m_mis;

  wb_regfile dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rd_from_wb            (rd_from_wb),
    .write_reg_from_wb     (write_reg_from_wb),
    .read_mem_from_wb      (read_mem_from_wb),
    .funct3_from_wb        (funct3_from_wb),
    .result_from_wb        (result_from_wb),
    .data_from_mem_from_wb (data_from_mem_from_wb),
    .rs1_addr              (rs1_addr),
    .rs2_addr              (rs2_addr),
    .rs1_data              (rs1_data),
    .rs2_data              (rs2_data),
    .load_misalign         (load_misalign),
    .retire_cnt            (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Load value straight from the size/sign rules.
  function automatic logic [31:0] load_val(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000: return (b[7] ? b | 32'hFFFF_FF00 : b);
      3'b100: return b;
      3'b001: return (h[15] ? h | 32'hFFFF_0000 : h);
      3'b101: return h;
      default: return w;
    endcase
  endfunction

  function automatic bit is_mis();
    bit half;
    bit word;
    half = (funct3_from_wb == 3'b001) || (funct3_from_wb == 3'b101);
    word = !half && (funct3_from_wb != 3'b000) &&
           (funct3_from_wb != 3'b100);
    if (write_reg_from_wb !== 1'b1) return 1'b0;
    if (read_mem_from_wb !== 1'b1) return 1'b0;
    if (half && result_from_wb[0]) return 1'b1;
    if (word && (result_from_wb[1:0] != 2'b00)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit commits();
    return (write_reg_from_wb === 1'b1) && (rd_from_wb != 5'd0) &&
           !is_mis();
  endfunction

  function automatic logic [31:0] wb_value();
    if (read_mem_from_wb) begin
      return load_val(funct3_from_wb, result_from_wb,
                      data_from_mem_from_wb);
    end
    return result_from_wb;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (commits() && a == rd_from_wb) return wb_value();
    return m_reg[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_cnt = 32'd0;
      m_mis = 1'b0;
    end else begin
      m_mis = is_mis();
      if (commits()) begin
        m_reg[rd_from_wb] = wb_value();
        m_cnt = m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rs1_data", rs1_data, exp_read(rs1_addr));
      check("rs2_data", rs2_data, exp_read(rs2_addr));
      check("retire_cnt", retire_cnt, m_cnt);
      check("load_misalign", {31'd0, load_misalign}, {31'd0, m_mis});
    end
  end

  task automatic drive(input logic we, input logic [4:0] rd,
                       input logic rm, input logic [2:0] f3,
                       input logic [31:0] res, input logic [31:0] mem,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    write_reg_from_wb     = we;
    rd_from_wb            = rd;
    read_mem_from_wb      = rm;
    funct3_from_wb        = f3;
    result_from_wb        = res;
    data_from_mem_from_wb = mem;
    rs1_addr              = a1;
    rs2_addr              = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 5'd0, 1'b0, 3'b000, 32'd0, 32'd0, a1, a2);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_cnt = 32'd0;
    m_mis = 1'b0;
    rst_n = 1'b0;
    write_reg_from_wb     = 1'b0;
    rd_from_wb            = 5'd0;
    read_mem_from_wb      = 1'b0;
    funct3_from_wb        = 3'd0;
    result_from_wb        = 32'd0;
    data_from_mem_from_wb = 32'd0;
    rs1_addr              = 5'd0;
    rs2_addr              = 5'd0;
    chk_en = 1'b1;
    #12 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      at_neg();
      check("reset_rs1", rs1_data, 32'd0);
      check("reset_rs2", rs2_data, 32'd0);
    end
    check("reset_cnt", retire_cnt, 32'd0);

    drive(1'b1, 5'd5, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 5'd0);
    at_neg();
    check("bypass_x5", rs1_data, 32'h1234_5678);
    idle(5'd5, 5'd5);
    at_neg();
    check("stored_x5", rs2_data, 32'h1234_5678);
    check("cnt_after_x5", retire_cnt, 32'd1);

    drive(1'b1, 5'd7, 1'b1, 3'b000, 32'h1003, 32'h80FF_7F01, 5'd0, 5'd0);
    idle(5'd7, 5'd0);
    at_neg();
    check("lb_x7", rs1_data, 32'hFFFF_FF80);
    drive(1'b1, 5'd7, 1'b1, 3'b100, 32'h1003, 32'h80FF_7F01, 5'd0, 5'd0);
    idle(5'd7, 5'd0);
    at_neg();
    check("lbu_x7", rs1_data, 32'h0000_0080);
    drive(1'b1, 5'd7, 1'b1, 3'b101, 32'h1002, 32'h80FF_7F01, 5'd0, 5'd0);
    idle(5'd7, 5'd0);
    at_neg();
    check("lhu_x7", rs1_data, 32'h0000_80FF);
    check("cnt_after_loads", retire_cnt, 32'd4);

    drive(1'b1, 5'd9, 1'b1, 3'b010, 32'h1002, 32'hCAFE_F00D, 5'd9, 5'd9);
    at_neg();
    check("lw_mis_nobypass", rs1_data, 32'd0);
    check("lw_mis_prepulse", {31'd0, load_misalign}, 32'd0);
    idle(5'd9, 5'd0);
    at_neg();
    check("lw_mis_pulse", {31'd0, load_misalign}, 32'd1);
    check("lw_mis_x9", rs1_data, 32'd0);
    check("lw_mis_cnt", retire_cnt, 32'd4);
    idle(5'd0, 5'd0);
    at_neg();
    check("lw_mis_pulse_end", {31'd0, load_misalign}, 32'd0);

    drive(1'b1, 5'd0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd0);
    at_neg();
    check("x0_rs1", rs1_data, 32'd0);
    check("x0_rs2", rs2_data, 32'd0);
    idle(5'd0, 5'd0);
    at_neg();
    check("x0_cnt", retire_cnt, 32'd4);

    // Idle cycles with undriven writeback fields.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      write_reg_from_wb     = 1'b0;
      rd_from_wb            = 'x;
      read_mem_from_wb      = 'x;
      funct3_from_wb        = 'x;
      result_from_wb        = 'x;
      data_from_mem_from_wb = 'x;
      rs1_addr              = 5'd5;
      rs2_addr              = 5'd7;
    end

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      logic [4:0] a1;
      logic [4:0] a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), rd,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, a1, a2);
    end

    idle(5'd0, 5'd0);
    force dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    at_neg();
    check("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 5'd5, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    at_neg();
    check("cnt_wrap", retire_cnt, 32'd0);
    check("wrap_x5", rs1_data, 32'h1234_5678);

    drive(1'b1, 5'd9, 1'b1, 3'b001, 32'h2001, 32'd0, 5'd5, 5'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rs1", rs1_data, 32'd0);
    check("async_cnt", retire_cnt, 32'd0);
    check("async_mis", {31'd0, load_misalign}, 32'd0);
    drive(1'b1, 5'd5, 1'b0, 3'b000, 32'hAAAA_5555, 32'd0, 5'd5, 5'd5);
    @(posedge clk);
    #1;
    check("rst_hold_cnt", retire_cnt, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_commit_cnt", retire_cnt, 32'd1);
    idle(5'd5, 5'd0);
    at_neg();
    check("first_commit_x5", rs1_data, 32'hAAAA_5555);

    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end
    idle(5'd0, 5'd0);
    at_neg();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: rd_from_wb  input  5  destination register index from MEM/WB stage.
REQ-004 SHALL have port: write_reg_from_wb  input  1  register write enable from MEM/WB stage.
REQ-005 SHALL have port: read_mem_from_wb  input  1  1 = writeback value is load data, 0 = ALU result.
REQ-006 SHALL have port: funct3_from_wb  input  3  load size/sign code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 SHALL have port: result_from_wb  input  32  ALU result; for loads, the byte address.
REQ-008 SHALL have port: data_from_mem_from_wb  input  32  raw aligned 32-bit word read from data memory.
REQ-009 SHALL have ports: rs1_addr, rs2_addr  input  5 each  decode-stage read indices.
REQ-010 SHALL have ports: rs1_data, rs2_data  output  32 each  read data.
REQ-011 SHALL have port: load_misalign  output  1  registered one-cycle pulse on a misaligned load writeback.
REQ-012 SHALL have port: retire_cnt  output  32  count of committed register writes.

Function
REQ-013 SHALL hold 31 architectural 32-bit registers x1..x31; x0 SHALL read 0 and never be written.
REQ-014 Writeback value SHALL be result_from_wb when read_mem_from_wb=0, else the extracted load value per REQ-015..017.
REQ-015 Byte select: offset = result_from_wb[1:0]; LB/LBU take byte[offset]; LB sign-extends bit 7, LBU zero-extends.
REQ-016 Half select: LH/LHU take bits [31:16] when result_from_wb[1]=1, else [15:0]; LH sign-extends, LHU zero-extends.
REQ-017 LW SHALL pass data_from_mem_from_wb unchanged; funct3 011/110/111 with read_mem_from_wb=1 SHALL be treated as LW.
REQ-018 Misaligned load = LH/LHU with result_from_wb[0]=1, or LW with result_from_wb[1:0]!=00; SHALL suppress the register write and pulse load_misalign high for exactly the following cycle.
REQ-019 Commit condition: write_reg_from_wb=1, rd_from_wb!=0, not misaligned; on commit the register SHALL update at the rising clk edge and retire_cnt SHALL increment by 1.
REQ-020 retire_cnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without flag.
REQ-021 Read ports SHALL be combinational; read index 0 SHALL return 0 regardless of bypass.
REQ-022 Write-through bypass: when a commit condition holds this cycle and rs*_addr==rd_from_wb, rs*_data SHALL return the writeback value in the same cycle; both ports SHALL bypass independently and simultaneously.
REQ-023 A suppressed write (enable low, rd=0, or misaligned) SHALL NOT bypass; reads return stored value.
REQ-024 Inputs with X/Z while write_reg_from_wb=0 SHALL NOT alter state.

Reset
REQ-025 On rst_n low, asynchronously: all x1..x31 = 0, retire_cnt = 0, load_misalign = 0.
REQ-026 During reset rs1_data/rs2_data SHALL read 0; no write SHALL commit while rst_n is low.
REQ-027 Reset deasserting mid-operation SHALL make the first commit occur at the first rising edge with rst_n high.

Verification
REQ-028 Reset, then read all 32 indices -> every rs*_data = 0x00000000, retire_cnt = 0.
REQ-029 ALU write rd=5, result=0x12345678, rs1_addr=5 same cycle -> rs1_data=0x12345678 (bypass); next cycle stored; retire_cnt=1.
REQ-030 LB, addr=0x1003, mem word=0x80FF7F01 -> x7=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x1002 -> 0x000080FF.
REQ-031 LW addr=0x1002 with rd=9 -> x9 unchanged, load_misalign=1 for one cycle, retire_cnt unchanged, no bypass.
REQ-032 Write rd=0 value 0xDEADBEEF with rs1_addr=rs2_addr=0 -> both read 0, retire_cnt unchanged.
REQ-033 Preload retire_cnt to 0xFFFFFFFF via 2^32-1 commits (or force), one more commit -> retire_cnt=0; assert rst_n low mid-cycle -> all state 0 immediately.
